// File: rtl/ctrl_cas_sched.sv
// In-order CAS scheduler: queues column commands behind their tRCD wait and
// releases the head once the command-to-command gap from the last CAS is met.
module ctrl_cas_sched #(
    parameter int DEPTH = 4,
    parameter int BG_W  = 2,
    parameter int CNT_W = 6
) (
    input  logic                     CK_t,
    input  logic                     reset,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic [2:0]               act_cmd,
    input  logic [BG_W-1:0]          act_bg,
    input  logic                     act_hit,
    output logic                     cas_valid,
    input  logic                     cas_ready,
    output logic [2:0]               cas_cmd,
    output logic [BG_W-1:0]          cas_bg,
    input  logic [CNT_W-1:0]         tRCD,
    input  logic [CNT_W-1:0]         tCCD_S,
    input  logic [CNT_W-1:0]         tCCD_L,
    input  logic [CNT_W-1:0]         tRTW,
    input  logic [CNT_W-1:0]         tWTR_S,
    input  logic [CNT_W-1:0]         tWTR_L,
    output logic                     cas_idle,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     cmd_err
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] RD_R  = 3'd1;
    localparam logic [2:0] RDA_R = 3'd2;
    localparam logic [2:0] WR_R  = 3'd3;
    localparam logic [2:0] WRA_R = 3'd4;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RCD,
        WAIT_GAP,
        ISSUE
    } state_t;

    state_t                       state_reg, state_next;
    logic [2:0]                   cmd_mem [DEPTH];
    logic [BG_W-1:0]              bg_mem  [DEPTH];
    logic [DEPTH-1:0][CNT_W-1:0]  rcd_all;
    logic [DEPTH-1:0][CNT_W-1:0]  rcd_nxt_all;
    logic [PTR_W-1:0]             rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]             wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]               count_reg, count_next;
    logic [CNT_W-1:0]             since_reg, since_next;
    logic                         last_valid_reg, last_valid_next;
    logic                         last_wr_reg, last_wr_next;
    logic [BG_W-1:0]              last_bg_reg, last_bg_next;
    logic                         cmd_err_reg;

    logic                         cmd_ok;
    logic                         push;
    logic                         pop;
    logic [2:0]                   head_cmd;
    logic [BG_W-1:0]              head_bg;
    logic [2:0]                   head_cmd_next;
    logic [BG_W-1:0]              head_bg_next;
    logic [CNT_W-1:0]             head_rcd_next;
    logic [CNT_W-1:0]             gap_next;

    function automatic logic is_wr(input logic [2:0] cmd);
        return (cmd == WR_R) || (cmd == WRA_R);
    endfunction

    // Required spacing between the last issued CAS and a candidate.
    function automatic logic [CNT_W-1:0] gap_for(
        input logic [2:0]      cmd,
        input logic [BG_W-1:0] bg,
        input logic            lv,
        input logic            lw,
        input logic [BG_W-1:0] lbg
    );
        logic            same_bg;
        logic [CNT_W-1:0] g;
        same_bg = (bg == lbg);
        if (!lv)
            g = '0;
        else if (is_wr(cmd) == lw)
            g = same_bg ? tCCD_L : tCCD_S;
        else if (!lw)
            g = tRTW;
        else
            g = same_bg ? tWTR_L : tWTR_S;
        return g;
    endfunction

    assign cmd_ok    = act_cmd inside {RD_R, RDA_R, WR_R, WRA_R};
    assign act_ready = (count_reg < FULL_CNT);
    assign push      = act_valid & act_ready & cmd_ok;
    assign pop       = cas_valid & cas_ready;

    assign head_cmd  = cmd_mem[rd_ptr_reg];
    assign head_bg   = bg_mem[rd_ptr_reg];

    // The state register already encodes eligibility, so cas_valid is a flop.
    assign cas_valid = (state_reg == ISSUE);
    assign cas_cmd   = (count_reg == '0) ? 3'd0 : head_cmd;
    assign cas_bg    = (count_reg == '0) ? '0 : head_bg;
    assign cas_idle  = (state_reg == IDLE);
    assign q_count   = count_reg;
    assign cmd_err   = cmd_err_reg;

    // Per-entry activate-to-CAS countdown, loaded on accept and free-running to 0.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [CNT_W-1:0] rcd_q;
        logic [CNT_W-1:0] rcd_d;

        always_comb begin
            if (push && (wr_ptr_reg == PTR_W'(gi)))
                rcd_d = act_hit ? '0 : tRCD;
            else if (rcd_q != '0)
                rcd_d = rcd_q - CNT_W'(1);
            else
                rcd_d = '0;
        end

        always_ff @(posedge CK_t) begin
            if (reset)
                rcd_q <= '0;
            else
                rcd_q <= rcd_d;
        end

        assign rcd_all[gi]     = rcd_q;
        assign rcd_nxt_all[gi] = rcd_d;
    end

    always_comb begin
        rd_ptr_next     = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        wr_ptr_next     = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;

        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + (PTR_W+1)'(1);
        else if (pop && !push)
            count_next = count_reg - (PTR_W+1)'(1);

        if (pop)
            since_next = CNT_W'(1);
        else if (since_reg == CNT_MAX)
            since_next = CNT_MAX;
        else
            since_next = since_reg + CNT_W'(1);

        last_valid_next = pop ? 1'b1           : last_valid_reg;
        last_wr_next    = pop ? is_wr(head_cmd) : last_wr_reg;
        last_bg_next    = pop ? head_bg        : last_bg_reg;

        // A push landing on the next head slot means the queue was otherwise empty.
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_cmd_next = act_cmd;
            head_bg_next  = act_bg;
        end else begin
            head_cmd_next = cmd_mem[rd_ptr_next];
            head_bg_next  = bg_mem[rd_ptr_next];
        end
        head_rcd_next = rcd_nxt_all[rd_ptr_next];

        gap_next = gap_for(head_cmd_next, head_bg_next,
                           last_valid_next, last_wr_next, last_bg_next);

        if (count_next == '0)
            state_next = IDLE;
        else if (head_rcd_next != '0)
            state_next = WAIT_RCD;
        else if (since_next >= gap_next)
            state_next = ISSUE;
        else
            state_next = WAIT_GAP;
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_reg      <= IDLE;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            since_reg      <= CNT_MAX;
            last_valid_reg <= 1'b0;
            last_wr_reg    <= 1'b0;
            last_bg_reg    <= '0;
            cmd_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            since_reg      <= since_next;
            last_valid_reg <= last_valid_next;
            last_wr_reg    <= last_wr_next;
            last_bg_reg    <= last_bg_next;
            cmd_err_reg    <= act_valid & act_ready & ~cmd_ok;
        end
    end

    always_ff @(posedge CK_t) begin
        if (push) begin
            cmd_mem[wr_ptr_reg] <= act_cmd;
            bg_mem[wr_ptr_reg]  <= act_bg;
        end
    end

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// Directed bench for ctrl_cas_sched: expected CAS handshakes (cmd, bg, cycle)
// are queued as requests are driven and matched by a negedge monitor.
module tb_ctrl_cas_sched;

    localparam logic [2:0] RD_R  = 3'd1;
    localparam logic [2:0] RDA_R = 3'd2;
    localparam logic [2:0] WR_R  = 3'd3;
    localparam logic [2:0] WRA_R = 3'd4;

    logic       CK_t = 1'b0;
    logic       reset = 1'b1;
    logic       act_valid = 1'b0;
    logic       act_ready;
    logic [2:0] act_cmd = 3'd0;
    logic [1:0] act_bg = 2'd0;
    logic       act_hit = 1'b0;
    logic       cas_valid;
    logic       cas_ready = 1'b0;
    logic [2:0] cas_cmd;
    logic [1:0] cas_bg;
    logic [5:0] tRCD = 6'd0, tCCD_S = 6'd0, tCCD_L = 6'd0;
    logic [5:0] tRTW = 6'd0, tWTR_S = 6'd0, tWTR_L = 6'd0;
    logic       cas_idle;
    logic [2:0] q_count;
    logic       cmd_err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] cmd;
        logic [1:0] bg;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    ctrl_cas_sched #(.DEPTH(4), .BG_W(2), .CNT_W(6)) dut (
        .CK_t(CK_t), .reset(reset),
        .act_valid(act_valid), .act_ready(act_ready), .act_cmd(act_cmd),
        .act_bg(act_bg), .act_hit(act_hit),
        .cas_valid(cas_valid), .cas_ready(cas_ready), .cas_cmd(cas_cmd), .cas_bg(cas_bg),
        .tRCD(tRCD), .tCCD_S(tCCD_S), .tCCD_L(tCCD_L),
        .tRTW(tRTW), .tWTR_S(tWTR_S), .tWTR_L(tWTR_L),
        .cas_idle(cas_idle), .q_count(q_count), .cmd_err(cmd_err)
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    // Handshake scoreboard plus a check that an offered CAS is never withdrawn.
    initial begin : monitor
        exp_t       e;
        logic       prev_hold;
        logic [2:0] prev_cmd;
        logic [1:0] prev_bg;
        prev_hold = 1'b0;
        prev_cmd  = 3'd0;
        prev_bg   = 2'd0;
        forever begin
            @(negedge CK_t);
            if (prev_hold && !reset) begin
                checks++;
                assert (cas_valid === 1'b1 && cas_cmd === prev_cmd && cas_bg === prev_bg) else begin
                    errors++;
                    $error("FAIL hold_stable cyc %0d: observed valid=%b cmd=%0d bg=%0d, expected valid=1 cmd=%0d bg=%0d",
                           cyc, cas_valid, cas_cmd, cas_bg, prev_cmd, prev_bg);
                end
            end
            prev_hold = cas_valid && !cas_ready && !reset;
            prev_cmd  = cas_cmd;
            prev_bg   = cas_bg;
            if (!reset && cas_valid && cas_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_cas cyc %0d: observed cmd=%0d bg=%0d, expected no CAS",
                           cyc, cas_cmd, cas_bg);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (cas_cmd === e.cmd && cas_bg === e.bg && cyc == e.cyc) else begin
                        errors++;
                        $error("FAIL cas_handshake: observed cmd=%0d bg=%0d cyc=%0d, expected cmd=%0d bg=%0d cyc=%0d",
                               cas_cmd, cas_bg, cyc, e.cmd, e.bg, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CK_t);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_t(input logic [5:0] rcd, input logic [5:0] ccds, input logic [5:0] ccdl,
                         input logic [5:0] rtw, input logic [5:0] wtrs, input logic [5:0] wtrl);
        tRCD = rcd; tCCD_S = ccds; tCCD_L = ccdl;
        tRTW = rtw; tWTR_S = wtrs; tWTR_L = wtrl;
    endtask

    // exp_cyc < 0 marks a request that is expected to be discarded, never issued.
    task automatic send(input logic [2:0] cmd, input logic [1:0] bg, input logic hit, input int exp_cyc);
        exp_t e;
        act_valid = 1'b1;
        act_cmd   = cmd;
        act_bg    = bg;
        act_hit   = hit;
        check("act_ready_on_send", int'(act_ready), 1);
        if (exp_cyc >= 0) begin
            e.cmd = cmd; e.bg = bg; e.cyc = exp_cyc;
            sb.push_back(e);
        end
        step();
        act_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: observed %0d CAS outstanding, expected 0", tag, sb.size());
            sb.delete();
        end
        step();
    endtask

    initial begin : stim
        int c0;
        int p;

        // Reset state
        do_reset();
        check("rst_cas_valid", int'(cas_valid), 0);
        check("rst_q_count",   int'(q_count), 0);
        check("rst_cas_idle",  int'(cas_idle), 1);
        check("rst_act_ready", int'(act_ready), 1);
        check("rst_cmd_err",   int'(cmd_err), 0);
        check("rst_cas_cmd",   int'(cas_cmd), 0);
        check("rst_cas_bg",    int'(cas_bg), 0);

        // tRCD = 14 miss: first cas_valid at cycle 15
        set_t(6'd14, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        do_reset();
        cas_ready = 1'b1;
        c0 = cyc;
        send(RD_R, 2'd0, 1'b0, c0 + 15);
        while (cyc < c0 + 14) step();
        check("rcd_wait_valid", int'(cas_valid), 0);
        check("rcd_wait_idle",  int'(cas_idle), 0);
        wait_drain("rcd14", 40);

        // tRCD = 0 miss behaves as a hit
        set_t(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        c0 = cyc;
        send(WR_R, 2'd3, 1'b0, c0 + 1);
        wait_drain("rcd0", 10);

        // tCCD_S / tCCD_L: handshakes at 1, 5, 11
        set_t(6'd5, 6'd4, 6'd6, 6'd0, 6'd0, 6'd0);
        do_reset();
        c0 = cyc;
        send(RD_R, 2'd0, 1'b1, c0 + 1);
        send(RD_R, 2'd1, 1'b1, c0 + 5);
        send(RD_R, 2'd1, 1'b1, c0 + 11);
        wait_drain("ccd", 30);

        // tRTW / tWTR_S: handshakes at 1, 9, 12
        set_t(6'd0, 6'd0, 6'd0, 6'd8, 6'd3, 6'd7);
        do_reset();
        c0 = cyc;
        send(RD_R, 2'd0, 1'b1, c0 + 1);
        send(WR_R, 2'd0, 1'b1, c0 + 9);
        send(RD_R, 2'd1, 1'b1, c0 + 12);
        wait_drain("rtw_wtrs", 30);

        // Auto-precharge variants: tWTR_L same bg, then tRTW
        do_reset();
        c0 = cyc;
        send(WRA_R, 2'd2, 1'b1, c0 + 1);
        send(RDA_R, 2'd2, 1'b1, c0 + 8);
        send(WR_R,  2'd1, 1'b1, c0 + 16);
        wait_drain("wtrl_ap", 30);

        // Gap of 1 and of 0 permit a CAS every cycle
        set_t(6'd0, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1);
        do_reset();
        c0 = cyc;
        send(RD_R,  2'd0, 1'b1, c0 + 1);
        send(WR_R,  2'd0, 1'b1, c0 + 2);
        send(RD_R,  2'd1, 1'b1, c0 + 3);
        send(WRA_R, 2'd1, 1'b1, c0 + 4);
        send(RDA_R, 2'd1, 1'b1, c0 + 5);
        wait_drain("gap1", 20);
        set_t(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        c0 = cyc;
        send(RD_R, 2'd2, 1'b1, c0 + 1);
        send(RD_R, 2'd2, 1'b1, c0 + 2);
        wait_drain("gap0", 20);

        // Full queue backpressure with simultaneous accept and pop
        do_reset();
        cas_ready = 1'b0;
        c0 = cyc;
        p  = c0 + 6;
        send(RD_R, 2'd0, 1'b1, p);
        send(WR_R, 2'd1, 1'b1, p + 1);
        send(RD_R, 2'd2, 1'b1, p + 2);
        send(WR_R, 2'd3, 1'b1, p + 3);
        check("full_act_ready", int'(act_ready), 0);
        check("full_q_count",   int'(q_count), 4);
        act_valid = 1'b1;
        act_cmd   = RDA_R;
        act_bg    = 2'd1;
        act_hit   = 1'b1;
        begin
            exp_t e5;
            e5.cmd = RDA_R; e5.bg = 2'd1; e5.cyc = p + 4;
            sb.push_back(e5);
        end
        while (cyc < p) begin
            step();
            check("full_hold_ready", int'(act_ready), 0);
        end
        cas_ready = 1'b1;
        step();
        check("ready_after_pop", int'(act_ready), 1);
        check("count_after_pop", int'(q_count), 3);
        step();
        act_valid = 1'b0;
        check("count_push_pop", int'(q_count), 3);
        wait_drain("full", 20);

        // Illegal command codes: cmd_err pulse, queue untouched
        do_reset();
        cas_ready = 1'b1;
        act_valid = 1'b1;
        act_cmd   = 3'b111;
        act_bg    = 2'd0;
        act_hit   = 1'b1;
        step();
        act_valid = 1'b0;
        check("err_pulse",      int'(cmd_err), 1);
        check("err_q_count",    int'(q_count), 0);
        step();
        check("err_one_cycle",  int'(cmd_err), 0);
        check("err_no_valid",   int'(cas_valid), 0);
        cas_ready = 1'b0;
        c0 = cyc;
        send(RD_R, 2'd0, 1'b1, c0 + 3);
        act_valid = 1'b1;
        act_cmd   = 3'd0;
        step();
        act_valid = 1'b0;
        check("err2_pulse",     int'(cmd_err), 1);
        check("err2_q_count",   int'(q_count), 1);
        step();
        check("err2_one_cycle", int'(cmd_err), 0);
        cas_ready = 1'b1;
        wait_drain("err", 10);

        // Reset mid-operation clears queue and the last-CAS record
        set_t(6'd0, 6'd30, 6'd30, 6'd2, 6'd30, 6'd30);
        do_reset();
        cas_ready = 1'b1;
        c0 = cyc;
        send(RD_R, 2'd0, 1'b1, c0 + 1);
        send(WR_R, 2'd1, 1'b1, -1);
        cas_ready = 1'b0;
        send(RD_R, 2'd0, 1'b1, -1);
        send(RD_R, 2'd1, 1'b1, -1);
        check("pre_rst_valid",   int'(cas_valid), 1);
        check("pre_rst_q_count", int'(q_count), 3);
        reset     = 1'b1;
        cas_ready = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid",   int'(cas_valid), 0);
        check("mid_rst_q_count", int'(q_count), 0);
        check("mid_rst_idle",    int'(cas_idle), 1);
        check("mid_rst_cmd",     int'(cas_cmd), 0);
        c0 = cyc;
        send(RD_R, 2'd0, 1'b1, c0 + 1);
        wait_drain("mid_rst", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
